// File: rtl/extbus_ctl_if.sv
// ============================================================================
// Module   : extbus_ctl_if
// Brief    : Cache-side request/reply and memory-side beat signals of the
//            external bus controller, with controller (slave) and
//            environment (master) views.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface extbus_ctl_if;
   logic        phi2;
   logic        extreq;
   logic        extwr;
   logic [4:0]  extsz;
   logic        extsrc;
   logic [31:0] extaddr;
   logic [63:0] extwdata;
   logic        extrdy;
   logic        extreply;
   logic        extreplyto;
   logic [63:0] extrdata;
   logic [28:0] memaddr;
   logic        memrd;
   logic        memwr;
   logic [63:0] memwdata;
   logic [63:0] memrdata;
   logic        memack;

   modport slave (
      input  phi2, extreq, extwr, extsz, extsrc, extaddr, extwdata,
             memrdata, memack,
      output extrdy, extreply, extreplyto, extrdata,
             memaddr, memrd, memwr, memwdata
   );

   modport master (
      output phi2, extreq, extwr, extsz, extsrc, extaddr, extwdata,
             memrdata, memack,
      input  extrdy, extreply, extreplyto, extrdata,
             memaddr, memrd, memwr, memwdata
   );
endinterface

`default_nettype wire

// File: rtl/extbus_ctl.sv
// ============================================================================
// Module   : extbus_ctl
// Brief    : Turns single cache requests into 1/2/4-beat memory transfers,
//            advancing only on phi2-enabled clock edges.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module extbus_ctl (
   input  wire logic      clk,
   input  wire logic      reset,
   extbus_ctl_if.slave    bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  r_beat;
   logic [1:0]  r_last;
   logic [28:0] r_base;
   logic        r_src;

   logic [1:0]  w_last_nxt;
   logic [28:0] w_beat_addr;
   logic        w_busy;
   logic        w_step;
   logic        w_live;
   logic        w_unused;

   // Low address bits select a byte inside the doubleword and are not used.
   assign w_unused = &{1'b0, bus.extaddr[2:0]};

   always_comb begin
      w_last_nxt = 2'd0;
      case (bus.extsz)
         5'd31:   w_last_nxt = 2'd3;
         5'd15:   w_last_nxt = 2'd1;
         default: w_last_nxt = 2'd0;
      endcase
   end

   // 4-beat bursts count upward with wrap; 2-beat bursts go critical-word-first.
   always_comb begin
      w_beat_addr = r_base;
      case (r_last)
         2'd3:    w_beat_addr = r_base + {27'd0, r_beat};
         2'd1:    w_beat_addr = r_base ^ {27'd0, r_beat};
         default: w_beat_addr = r_base;
      endcase
   end

   assign w_busy = (r_state == S_RD) || (r_state == S_WR);
   assign w_step = w_busy & bus.phi2 & bus.memack;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_beat  <= 2'd0;
         r_last  <= 2'd0;
         r_base  <= 29'd0;
         r_src   <= 1'b0;
      end else if (bus.phi2) begin
         case (r_state)
            S_IDLE: begin
               if (bus.extreq) begin
                  r_base  <= bus.extaddr[31:3];
                  r_src   <= bus.extsrc;
                  r_last  <= w_last_nxt;
                  r_beat  <= 2'd0;
                  r_state <= bus.extwr ? S_WR : S_RD;
               end
            end
            S_RD, S_WR: begin
               if (bus.memack) begin
                  if (r_beat == r_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Every output is forced low while reset is held, including extrdy.
   assign w_live          = ~reset;
   assign bus.extrdy      = w_live & (r_state == S_IDLE);
   assign bus.memrd       = w_live & (r_state == S_RD);
   assign bus.memwr       = w_live & (r_state == S_WR);
   assign bus.extreply    = w_live & w_step;
   assign bus.extreplyto  = w_live & r_src;
   assign bus.memaddr     = (w_live & w_busy) ? w_beat_addr : 29'd0;
   assign bus.extrdata    = (w_live & w_step & (r_state == S_RD)) ? bus.memrdata : 64'd0;
   assign bus.memwdata    = w_live ? bus.extwdata : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_extbus_ctl.sv
// ============================================================================
// Module   : tb_extbus_ctl
// Brief    : Scoreboard bench for extbus_ctl: expected beats are queued at
//            request time and popped on each extreply.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_extbus_ctl;

   typedef struct packed {
      logic [28:0] addr;
      logic [63:0] data;
      logic        src;
      logic        wr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic phi2_lvl = 1'b1;
   logic phi2_alt = 1'b0;
   logic phi2_tgl = 1'b0;
   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   extbus_ctl_if bus();

   extbus_ctl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      phi2_tgl = ~phi2_tgl;
   end

   function automatic logic [63:0] mem_word(input logic [28:0] a);
      return {3'b101, a, 3'b011, a ^ 29'h1555_5555};
   endfunction

   assign bus.phi2     = phi2_alt ? phi2_tgl : phi2_lvl;
   assign bus.memrdata = mem_word(bus.memaddr);

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_beat(input logic [28:0] a, input logic s, input logic w, input logic [63:0] d);
      exp_t e;
      e.addr = a;
      e.src  = s;
      e.wr   = w;
      e.data = w ? d : mem_word(a);
      q.push_back(e);
   endtask

   // Presents a request and drops it right after the first phi2 edge.
   task automatic start_req(input logic w, input logic [4:0] sz, input logic [31:0] a,
                            input logic s, input logic [63:0] wd);
      logic p;
      p = 1'b0;
      @(posedge clk); #1;
      bus.extwr    = w;
      bus.extsz    = sz;
      bus.extaddr  = a;
      bus.extsrc   = s;
      bus.extwdata = wd;
      bus.extreq   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         p = bus.phi2;
         @(posedge clk); #1;
         if (p) break;
      end
      bus.extreq = 1'b0;
      check_eq("rdy_after_accept", {63'd0, bus.extrdy}, 64'd0);
   endtask

   task automatic wait_idle(input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.extrdy) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("idle_wait", {63'd0, ok}, 64'd1);
      check_eq("sb_empty", 64'(q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (bus.extreply) begin
         if (q.size() == 0) begin
            check_eq("extra_reply", 64'd1, 64'd0);
         end else begin
            mon_e = q.pop_front();
            check_eq("beat_addr", {35'd0, bus.memaddr}, {35'd0, mon_e.addr});
            check_eq("replyto", {63'd0, bus.extreplyto}, {63'd0, mon_e.src});
            check_eq("memwr", {63'd0, bus.memwr}, {63'd0, mon_e.wr});
            check_eq("memrd", {63'd0, bus.memrd}, {63'd0, ~mon_e.wr});
            if (mon_e.wr) check_eq("memwdata", bus.memwdata, mon_e.data);
            else          check_eq("extrdata", bus.extrdata, mon_e.data);
         end
      end else if (bus.memrd) begin
         check_eq("rdata_no_reply", bus.extrdata, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.extreq   = 1'b1;
      bus.extwr    = 1'b0;
      bus.extsz    = 5'd31;
      bus.extsrc   = 1'b1;
      bus.extaddr  = 32'h100;
      bus.extwdata = 64'd0;
      bus.memack   = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_extrdy", {63'd0, bus.extrdy}, 64'd0);
      check_eq("rst_memrd", {63'd0, bus.memrd}, 64'd0);
      check_eq("rst_memwr", {63'd0, bus.memwr}, 64'd0);
      check_eq("rst_reply", {63'd0, bus.extreply}, 64'd0);
      check_eq("rst_memaddr", {35'd0, bus.memaddr}, 64'd0);
      @(posedge clk); #1;
      bus.extreq = 1'b0;
      reset      = 1'b0;
      bus.memack = 1'b1;
      @(negedge clk);
      check_eq("post_rst_rdy", {63'd0, bus.extrdy}, 64'd1);
      check_eq("post_rst_replyto", {63'd0, bus.extreplyto}, 64'd0);

      // icache 4-beat read
      for (int i = 0; i < 4; i++) push_beat(29'h20 + 29'(i), 1'b0, 1'b0, 64'd0);
      start_req(1'b0, 5'd31, 32'h100, 1'b0, 64'd0);
      wait_idle(20);

      // dcache 2-beat read, critical word first, phi2 alternating
      phi2_alt = 1'b1;
      push_beat(29'h21, 1'b1, 1'b0, 64'd0);
      push_beat(29'h20, 1'b1, 1'b0, 64'd0);
      start_req(1'b0, 5'd15, 32'h108, 1'b1, 64'd0);
      wait_idle(30);
      phi2_alt = 1'b0;
      check_eq("replyto_hold", {63'd0, bus.extreplyto}, 64'd1);

      // request while phi2 is low is ignored
      @(posedge clk); #1;
      phi2_lvl   = 1'b0;
      bus.extreq = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("phi2_low_ignored", {63'd0, bus.extrdy}, 64'd1);
      bus.extreq = 1'b0;
      phi2_lvl   = 1'b1;

      // single write with memack held low
      bus.memack = 1'b0;
      push_beat(29'h4, 1'b0, 1'b1, 64'hDEADBEEF_CAFEBABE);
      start_req(1'b1, 5'd3, 32'h20, 1'b0, 64'hDEADBEEF_CAFEBABE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("wr_wait_memwr", {63'd0, bus.memwr}, 64'd1);
         check_eq("wr_wait_addr", {35'd0, bus.memaddr}, 64'h4);
         check_eq("wr_wait_reply", {63'd0, bus.extreply}, 64'd0);
      end
      @(posedge clk); #1;
      phi2_lvl   = 1'b0;
      bus.memack = 1'b1;
      @(negedge clk);
      check_eq("ack_no_phi2_reply", {63'd0, bus.extreply}, 64'd0);
      check_eq("ack_no_phi2_memwr", {63'd0, bus.memwr}, 64'd1);
      @(posedge clk); #1;
      phi2_lvl = 1'b1;
      wait_idle(10);

      // 4-beat read wrapping at the top of the doubleword space
      push_beat(29'h1FFF_FFFF, 1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 3; i++) push_beat(29'(i), 1'b0, 1'b0, 64'd0);
      start_req(1'b0, 5'd31, 32'hFFFF_FFF8, 1'b0, 64'd0);
      wait_idle(20);

      // reset after two beats of a 4-beat read
      push_beat(29'h20, 1'b1, 1'b0, 64'd0);
      push_beat(29'h21, 1'b1, 1'b0, 64'd0);
      start_req(1'b0, 5'd31, 32'h100, 1'b1, 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_reply", {63'd0, bus.extreply}, 64'd0);
      check_eq("abort_memrd", {63'd0, bus.memrd}, 64'd0);
      check_eq("abort_extrdy", {63'd0, bus.extrdy}, 64'd0);
      check_eq("abort_replyto", {63'd0, bus.extreplyto}, 64'd0);
      check_eq("abort_memaddr", {35'd0, bus.memaddr}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("abort_release_rdy", {63'd0, bus.extrdy}, 64'd1);
      check_eq("abort_release_memrd", {63'd0, bus.memrd}, 64'd0);
      check_eq("abort_src_cleared", {63'd0, bus.extreplyto}, 64'd0);
      check_eq("abort_sb_empty", 64'(q.size()), 64'd0);
      repeat (3) @(negedge clk);

      // extreq held through a busy read, new address taken only after IDLE
      for (int i = 0; i < 4; i++) push_beat(29'h20 + 29'(i), 1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 4; i++) push_beat(29'h40 + 29'(i), 1'b0, 1'b0, 64'd0);
      @(posedge clk); #1;
      bus.extwr   = 1'b0;
      bus.extsz   = 5'd31;
      bus.extaddr = 32'h100;
      bus.extsrc  = 1'b0;
      bus.extreq  = 1'b1;
      @(posedge clk); #1;
      check_eq("busy_rdy_low", {63'd0, bus.extrdy}, 64'd0);
      bus.extaddr = 32'h200;
      begin
         logic ok;
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.extrdy) begin
               ok = 1'b1;
               break;
            end
         end
         check_eq("busy_return_idle", {63'd0, ok}, 64'd1);
      end
      check_eq("busy_first_done", 64'(q.size()), 64'd4);
      @(posedge clk); #1;
      check_eq("reaccept_first_edge", {63'd0, bus.extrdy}, 64'd0);
      bus.extreq = 1'b0;
      wait_idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
